param_router_accum: RTL and testbench
=====================================

# param_router_accum

Parametrised scatter-accumulate stage for the sparse CNN output tile. Accepts N_IN sparse partial products per cycle, each tagged with an output-tile address, and adds each into one of N_ACC accumulator registers. Same-address collisions within a cycle are summed. A drain state machine then streams the tile out serially over a valid/ready port, clearing each entry as it is read. The block sits between the multiplier array and the output/ReLU stage and supersedes the fixed 4x144 router-plus-buffer pair.

## Interface
Parameters:
- N_IN, 4, number of product lanes per cycle
- N_ACC, 144, number of accumulators (output tile entries)
- ADDR_W, 8, address field width; must satisfy 2^ADDR_W >= N_ACC
- DATA_W, 16, signed product width
- ACC_W, 20, signed accumulator width; must satisfy ACC_W >= DATA_W

Ports:
- clk  in  1  single clock; all logic on the rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  N_IN  per-lane valid
- in_data  in  N_IN*(ADDR_W+DATA_W)  lane k occupies bits [(k+1)*(ADDR_W+DATA_W)-1 : k*(ADDR_W+DATA_W)], packed as {addr, data}
- in_ready  out  1  high when lanes are accepted
- drain_start  in  1  single-cycle request to read out the tile
- out_valid  out  1  drain beat valid
- out_ready  in  1  downstream accepts the beat
- out_idx  out  ADDR_W  accumulator index of the current beat
- out_data  out  ACC_W  accumulator value of the current beat
- out_last  out  1  high on the beat where out_idx = N_ACC-1
- drain_done  out  1  one-cycle pulse after the last beat is accepted
- addr_err  out  1  sticky flag; set when a valid lane carries addr >= N_ACC
- sat_flag  out  1  sticky flag; see Configuration

## Operation
- Reset values: all accumulators 0, state IDLE, in_ready=1, out_valid=0, out_idx=0, out_data=0, out_last=0, drain_done=0, addr_err=0, sat_flag=0.
- Stage 1 registers the lanes that are valid and accepted (in_valid[k] & in_ready).
- Stage 2, per accumulator i: acc[i] += sum over registered lanes whose addr == i.
  - data is sign-extended to ACC_W before the add.
  - Any number of lanes that hit the same address in one cycle are all summed. None is dropped.
- A lane with addr >= N_ACC is discarded and sets addr_err. addr_err is cleared only by reset.
- State machine: IDLE -> FLUSH -> DRAIN -> IDLE.
  - IDLE: in_ready=1. On drain_start, go to FLUSH. drain_start outside IDLE is ignored.
  - FLUSH: in_ready=0 for 2 cycles, so the stage-1/stage-2 pipeline empties. Then go to DRAIN with idx=0.
  - DRAIN: out_valid=1, out_idx=idx, out_data=acc[idx].
  - DRAIN handshake: on out_valid & out_ready, acc[idx] is set to 0 and idx increments.
  - DRAIN exit: after the beat with idx = N_ACC-1 is accepted, pulse drain_done and return to IDLE.
- Inputs presented while in_ready=0 are ignored; the upstream stage must hold them.
- An asserted reset at any point, including mid-drain, returns every register to its reset value immediately. A partially drained tile is lost.

## Timing
- Accumulate latency: a lane accepted in cycle t is reflected in acc at t+2.
- Drain latency: drain_start in cycle t gives the first out_valid at t+3, after 2 FLUSH cycles. The drain includes every lane accepted up to t.
- Back-to-back drain: with out_ready held high, one beat per cycle, N_ACC beats total. drain_done is high in the cycle after the last beat.
- out_valid stalls: while out_valid=1 and out_ready=0, out_idx and out_data hold stable.
- Earliest restart: in_ready returns to 1 in the same cycle drain_done pulses.

## Configuration
- Macro: ACCUM_SAT_EN.
- Defined: each stage-2 sum is clamped to [-2^(ACC_W-1), 2^(ACC_W-1)-1]. Any clamp sets sat_flag, which is sticky until reset.
- Undefined: sums wrap modulo 2^ACC_W and sat_flag is tied to 0.

## Structure
- Package param_router_accum_pkg holds:
  - default parameter constants;
  - the lane-field extraction functions (addr, data);
  - the state enum {IDLE, FLUSH, DRAIN};
  - the saturate function.
- One sub-module, accum_cell, instanced N_ACC times via generate. Each cell:
  - takes N_IN registered lanes plus its own index;
  - matches addresses and forms the adder tree;
  - applies saturation or wrap;
  - has a clear-on-read input.

## Test plan
- Lanes 0..3 = {5,+10}, {5,-3}, {7,+100}, {143,+1} for one cycle, then drain -> beat idx5=7, idx7=100, idx143=1, all other beats 0. out_last on idx 143, then drain_done.
- Lanes 0..3 all {0,+32767} for 8 cycles, default ACC_W=20 -> acc0=1048544. Without ACCUM_SAT_EN the readout is -32 (wrap) and sat_flag=0. With the macro it is 524287 and sat_flag=1.
- Lane {200,+9} -> addr_err=1 and no accumulator changes. addr_err still 1 after a full drain.
- Drain with out_ready toggling 1,0,0,1 -> out_idx/out_data stable during the low cycles. 144 beats, no duplicates or skips. A second drain returns all zeros.
- drain_start in the same cycle as lane {3,+4} -> idx3=4 in the readout. Lanes asserted during FLUSH/DRAIN are not counted in this or the next tile.
- Reset asserted at beat idx 50 of a drain -> all outputs take their reset values in the same cycle. A subsequent drain reads all zeros.

Source files
------------

// File: rtl/param_router_accum_pkg.sv
// Shared types and helpers for param_router_accum.
// Defaults, lane-field extraction, state enum, saturation.
package param_router_accum_pkg;

  localparam int N_IN_DEF   = 4;
  localparam int N_ACC_DEF  = 144;
  localparam int ADDR_W_DEF = 8;
  localparam int DATA_W_DEF = 16;
  localparam int ACC_W_DEF  = 20;

  // Wide signed scratch width for sums of any supported config.
  localparam int XW = 64;
  typedef logic signed [XW-1:0] wide_t;

  typedef enum logic [1:0] {
    IDLE,
    FLUSH,
    DRAIN
  } state_t;

  // lane is the zero-extended {addr, data} field.
  function automatic wide_t lane_addr(input wide_t lane,
                                      input int dw,
                                      input int aw);
    wide_t m;
    m = (wide_t'(1) << aw) - wide_t'(1);
    return (lane >> dw) & m;
  endfunction

  // Returns the data field sign-extended to XW.
  function automatic wide_t lane_data(input wide_t lane,
                                      input int dw);
    wide_t m;
    wide_t d;
    m = (wide_t'(1) << dw) - wide_t'(1);
    d = lane & m;
    if (d[dw-1]) d = d | ~m;
    return d;
  endfunction

  function automatic wide_t saturate(input wide_t v,
                                     input int w);
    wide_t hi;
    wide_t lo;
    hi = (wide_t'(1) << (w - 1)) - wide_t'(1);
    lo = -hi - wide_t'(1);
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  function automatic logic sat_hit(input wide_t v,
                                   input int w);
    return saturate(v, w) != v;
  endfunction

endpackage

// File: rtl/param_router_accum_cell.sv
// One accumulator entry: address match, lane adder, sat/wrap, clear-on-read.
// Ports: clk, reset, vld/addr/data lanes, idx, clr -> acc, sat.
module accum_cell
  import param_router_accum_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_IN-1:0]   vld,
  input  logic [ADDR_W-1:0] addr [N_IN],
  input  logic [DATA_W-1:0] data [N_IN],
  input  logic [ADDR_W-1:0] idx,
  input  logic              clr,
  output logic [ACC_W-1:0]  acc,
  output logic              sat
);

  wide_t sum;
  wide_t nxt;

  always_comb begin
    sum = wide_t'($signed(acc));
    for (int k = 0; k < N_IN; k++) begin
      if (vld[k] && addr[k] == idx)
        sum = sum + wide_t'($signed(data[k]));
    end
  end

`ifdef ACCUM_SAT_EN
  assign nxt = saturate(sum, ACC_W);
  assign sat = sat_hit(sum, ACC_W);
`else
  assign nxt = sum;
  assign sat = 1'b0;
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)   acc <= '0;
    else if (clr) acc <= '0;
    else          acc <= ACC_W'(nxt);
  end

endmodule

// File: rtl/param_router_accum.sv
// Scatter-accumulate of N_IN tagged lanes into N_ACC entries, serial drain.
// Build with ACCUM_SAT_EN to clamp sums and drive sat_flag.
// Ports: clk, reset(n), in_valid/in_data/in_ready, drain_start,
//   out_valid/out_ready/out_idx/out_data/out_last, drain_done,
//   addr_err, sat_flag.
module param_router_accum
  import param_router_accum_pkg::*;
#(
  parameter int N_IN   = N_IN_DEF,
  parameter int N_ACC  = N_ACC_DEF,
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF,
  parameter int ACC_W  = ACC_W_DEF
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [N_IN-1:0]                 in_valid,
  input  logic [N_IN*(ADDR_W+DATA_W)-1:0] in_data,
  output logic                            in_ready,
  input  logic                            drain_start,
  output logic                            out_valid,
  input  logic                            out_ready,
  output logic [ADDR_W-1:0]               out_idx,
  output logic [ACC_W-1:0]                out_data,
  output logic                            out_last,
  output logic                            drain_done,
  output logic                            addr_err,
  output logic                            sat_flag
);

  localparam int LW = ADDR_W + DATA_W;
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(N_ACC - 1);

  state_t            state, state_n;
  logic              fcnt, fcnt_n;
  logic [ADDR_W-1:0] idx, idx_n;
  logic              done_n;

  wide_t             lw  [N_IN];
  logic [N_IN-1:0]   bad;
  logic [N_IN-1:0]   s1_vld;
  logic [ADDR_W-1:0] s1_addr [N_IN];
  logic [DATA_W-1:0] s1_data [N_IN];

  logic [ACC_W-1:0]  acc [N_ACC];
  logic [N_ACC-1:0]  cell_sat;

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == DRAIN);
  assign out_idx   = idx;
  assign out_last  = out_valid && idx == LAST;
  assign out_data  = out_valid ? acc[idx] : '0;

  always_comb begin
    for (int k = 0; k < N_IN; k++) begin
      lw[k]  = wide_t'(in_data[k*LW +: LW]);
      bad[k] = in_valid[k] && in_ready &&
               lane_addr(lw[k], DATA_W, ADDR_W) >= wide_t'(N_ACC);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_vld   <= '0;
      addr_err <= 1'b0;
      for (int k = 0; k < N_IN; k++) begin
        s1_addr[k] <= '0;
        s1_data[k] <= '0;
      end
    end else begin
      s1_vld   <= in_valid & {N_IN{in_ready}} & ~bad;
      addr_err <= addr_err | (|bad);
      for (int k = 0; k < N_IN; k++) begin
        s1_addr[k] <= ADDR_W'(lane_addr(lw[k], DATA_W, ADDR_W));
        s1_data[k] <= DATA_W'(lane_data(lw[k], DATA_W));
      end
    end
  end

  for (genvar i = 0; i < N_ACC; i++) begin : g_cell
    accum_cell #(
      .N_IN  (N_IN),
      .ADDR_W(ADDR_W),
      .DATA_W(DATA_W),
      .ACC_W (ACC_W)
    ) u_cell (
      .clk  (clk),
      .reset(reset),
      .vld  (s1_vld),
      .addr (s1_addr),
      .data (s1_data),
      .idx  (ADDR_W'(i)),
      .clr  (out_valid && out_ready && idx == ADDR_W'(i)),
      .acc  (acc[i]),
      .sat  (cell_sat[i])
    );
  end

  always_comb begin
    state_n = state;
    fcnt_n  = fcnt;
    idx_n   = idx;
    done_n  = 1'b0;
    unique case (state)
      IDLE: begin
        if (drain_start) begin
          state_n = FLUSH;
          fcnt_n  = 1'b0;
        end
      end
      FLUSH: begin
        if (fcnt) begin
          state_n = DRAIN;
          idx_n   = '0;
        end else begin
          fcnt_n = 1'b1;
        end
      end
      DRAIN: begin
        if (out_ready) begin
          if (idx == LAST) begin
            state_n = IDLE;
            idx_n   = '0;
            done_n  = 1'b1;
          end else begin
            idx_n = idx + 1'b1;
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      fcnt       <= 1'b0;
      idx        <= '0;
      drain_done <= 1'b0;
      sat_flag   <= 1'b0;
    end else begin
      state      <= state_n;
      fcnt       <= fcnt_n;
      idx        <= idx_n;
      drain_done <= done_n;
      sat_flag   <= sat_flag | (|cell_sat);
    end
  end

endmodule

// File: tb/tb_param_router_accum.sv
// Directed self-checking bench for param_router_accum.
// Drives and samples on the falling edge; DUT acts on the rising edge.
module tb_param_router_accum;

  localparam int N_IN   = 4;
  localparam int N_ACC  = 144;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam int ACC_W  = 20;
  localparam int LW     = ADDR_W + DATA_W;

  logic                 clk;
  logic                 reset;
  logic [N_IN-1:0]      in_valid;
  logic [N_IN*LW-1:0]   in_data;
  logic                 in_ready;
  logic                 drain_start;
  logic                 out_valid;
  logic                 out_ready;
  logic [ADDR_W-1:0]    out_idx;
  logic [ACC_W-1:0]     out_data;
  logic                 out_last;
  logic                 drain_done;
  logic                 addr_err;
  logic                 sat_flag;

  int checks = 0;
  int failures = 0;
  logic [ACC_W-1:0] expv [N_ACC];

  param_router_accum #(
    .N_IN  (N_IN),
    .N_ACC (N_ACC),
    .ADDR_W(ADDR_W),
    .DATA_W(DATA_W),
    .ACC_W (ACC_W)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_valid   (in_valid),
    .in_data    (in_data),
    .in_ready   (in_ready),
    .drain_start(drain_start),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_idx    (out_idx),
    .out_data   (out_data),
    .out_last   (out_last),
    .drain_done (drain_done),
    .addr_err   (addr_err),
    .sat_flag   (sat_flag)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #5ms;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int k, input int a, input int d);
    in_valid[k] = 1'b1;
    in_data[k*LW +: LW] = {8'(a), 16'(d)};
  endtask

  task automatic clr_lanes();
    in_valid = '0;
    in_data  = '0;
  endtask

  task automatic zero_exp();
    for (int i = 0; i < N_ACC; i++) expv[i] = '0;
  endtask

  task automatic chk_reset_outs(input string pfx);
    chk({pfx, "_in_ready"},   32'(in_ready),   32'd1);
    chk({pfx, "_out_valid"},  32'(out_valid),  32'd0);
    chk({pfx, "_out_idx"},    32'(out_idx),    32'd0);
    chk({pfx, "_out_data"},   32'(out_data),   32'd0);
    chk({pfx, "_out_last"},   32'(out_last),   32'd0);
    chk({pfx, "_drain_done"}, 32'(drain_done), 32'd0);
    chk({pfx, "_addr_err"},   32'(addr_err),   32'd0);
    chk({pfx, "_sat_flag"},   32'(sat_flag),   32'd0);
  endtask

  // Called at a falling edge with lanes possibly set for the start cycle.
  task automatic drain(input bit toggle, input bit noise, input int abort_at);
    int n;
    int b;
    int cyc;
    bit rdy;
    logic [3:0] pat;
    pat = 4'b1001;
    out_ready = 1'b1;
    drain_start = 1'b1;
    @(negedge clk);
    drain_start = 1'b0;
    clr_lanes();
    if (noise) set_lane(0, 9, 55);
    chk("flush_ready", 32'(in_ready), 32'd0);
    n = 0;
    while (!out_valid && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("drain_lat", 32'(n), 32'd2);
    b = 0;
    cyc = 0;
    while (b < N_ACC && cyc < 2000) begin
      if (b == abort_at) begin
        reset = 1'b0;
        #1;
        chk_reset_outs("mid_rst");
        clr_lanes();
        zero_exp();
        return;
      end
      rdy = toggle ? pat[3 - (cyc % 4)] : 1'b1;
      out_ready = rdy;
      chk("beat_vld",  32'(out_valid), 32'd1);
      chk("beat_idx",  32'(out_idx),   32'(b));
      chk("beat_data", 32'(out_data),  32'(expv[b]));
      chk("beat_last", 32'(out_last),  32'(b == N_ACC - 1));
      if (rdy) b++;
      cyc++;
      @(negedge clk);
    end
    chk("beats", 32'(b), 32'(N_ACC));
    chk("done_pulse", 32'(drain_done), 32'd1);
    chk("done_ready", 32'(in_ready),   32'd1);
    chk("done_vld",   32'(out_valid),  32'd0);
    clr_lanes();
    out_ready = 1'b1;
    zero_exp();
    @(negedge clk);
    chk("done_clr", 32'(drain_done), 32'd0);
  endtask

  initial begin
    reset = 1'b0;
    drain_start = 1'b0;
    out_ready = 1'b1;
    clr_lanes();
    zero_exp();
    @(negedge clk);
    @(negedge clk);
    chk_reset_outs("rst");
    reset = 1'b1;
    @(negedge clk);

    // Collision sum plus scattered lanes.
    set_lane(0, 5, 10);
    set_lane(1, 5, -3);
    set_lane(2, 7, 100);
    set_lane(3, 143, 1);
    @(negedge clk);
    clr_lanes();
    @(negedge clk);
    expv[5]   = 20'd7;
    expv[7]   = 20'd100;
    expv[143] = 20'd1;
    drain(1'b0, 1'b0, -1);

    // Overflow: 32 x 32767 into entry 0.
    for (int k = 0; k < N_IN; k++) set_lane(k, 0, 32767);
    repeat (8) @(negedge clk);
    clr_lanes();
    @(negedge clk);
    @(negedge clk);
`ifdef ACCUM_SAT_EN
    expv[0] = 20'd524287;
    chk("sat_flag", 32'(sat_flag), 32'd1);
`else
    expv[0] = 20'hFFFE0;
    chk("sat_flag", 32'(sat_flag), 32'd0);
`endif
    drain(1'b0, 1'b0, -1);

    // Out-of-range address.
    chk("addr_err_pre", 32'(addr_err), 32'd0);
    set_lane(1, 200, 9);
    @(negedge clk);
    clr_lanes();
    @(negedge clk);
    chk("addr_err_set", 32'(addr_err), 32'd1);
    drain(1'b0, 1'b0, -1);
    chk("addr_err_keep", 32'(addr_err), 32'd1);

    // Stalled drain, then confirm clear-on-read.
    set_lane(0, 50, -7);
    set_lane(2, 0, 3);
    @(negedge clk);
    clr_lanes();
    @(negedge clk);
    expv[50] = 20'hFFFF9;
    expv[0]  = 20'd3;
    drain(1'b1, 1'b0, -1);
    drain(1'b0, 1'b0, -1);

    // Lane in the drain_start cycle counts; later lanes do not.
    set_lane(0, 3, 4);
    expv[3] = 20'd4;
    drain(1'b0, 1'b1, -1);
    drain(1'b0, 1'b0, -1);

    // Reset in the middle of a drain.
    set_lane(0, 100, 77);
    @(negedge clk);
    clr_lanes();
    @(negedge clk);
    expv[100] = 20'd77;
    drain(1'b0, 1'b0, 50);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    drain(1'b0, 1'b0, -1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
